// File: rtl/sdram_axi_controller.sv
// Closed-page single-word SDR SDRAM controller behind a simplified AXI-style slave port.
// Handles power-up init, periodic auto-refresh, and ACTIVE + READ/WRITE with auto-precharge.
module sdram_axi_controller #(
    parameter int ADDR_WIDTH       = 25,
    parameter int DATA_WIDTH       = 16,
    parameter int INIT_CYCLES      = 20000,
    parameter int REFRESH_INTERVAL = 750,
    parameter int T_RP             = 2,
    parameter int T_RCD            = 2,
    parameter int T_RFC            = 7,
    parameter int T_MRD            = 2,
    parameter int T_WR             = 2,
    parameter int CAS_LATENCY      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [12:0]           sdram_addr,
    output logic [1:0]            sdram_ba,
    inout  logic [DATA_WIDTH-1:0] sdram_dq,
    output logic                  sdram_clk,
    output logic                  sdram_cke,
    output logic                  sdram_cs_n,
    output logic                  sdram_ras_n,
    output logic                  sdram_cas_n,
    output logic                  sdram_we_n,
    output logic                  sdram_dqml,
    output logic                  sdram_dqmh,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready
);
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    localparam int CNT_W  = 8;
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int REF_W  = $clog2(REFRESH_INTERVAL + 1);
    // Read turnaround covers both the data capture and tRP after the auto-precharge.
    localparam int RD_GAP = (CAS_LATENCY + 2 > T_RP + 1) ? CAS_LATENCY + 2 : T_RP + 1;
    localparam logic [2:0]  CL_BITS   = 3'(CAS_LATENCY);
    localparam logic [12:0] MODE_WORD = {6'b000000, CL_BITS, 4'b0000};

    typedef enum logic [2:0] {
        INIT_WAIT, INIT_PRE, INIT_REF, INIT_MRS, IDLE, WR_CMD, RD_CMD
    } state_t;

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [INIT_W-1:0]      init_cnt, init_cnt_nx;
    logic                   init_ref, init_ref_nx;
    logic                   init_done;
    logic [REF_W-1:0]       ref_cnt;
    logic                   ref_pending;
    logic [3:0]             cmd, cmd_nx;
    logic [12:0]            addr_q, addr_nx;
    logic [1:0]             ba_q, ba_nx;
    logic                   cke_q;
    logic                   dq_oe, dq_oe_nx;
    logic [DATA_WIDTH-1:0]  dq_out, dq_out_nx;
    logic [1:0]             acc_ba;
    logic [9:0]             acc_col;
    logic [DATA_WIDTH-1:0]  acc_data;
    logic                   aw_acc, ar_acc, rd_start, ref_issue, mrs_issue;
    logic [CAS_LATENCY:0]   rd_pipe;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   rvalid_q;

    assign sdram_clk   = ~clk;
    assign sdram_cke   = cke_q;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_addr  = addr_q;
    assign sdram_ba    = ba_q;
    assign sdram_dqml  = 1'b0;
    assign sdram_dqmh  = 1'b0;
    assign sdram_dq    = dq_oe ? dq_out : 'z;

    assign s_axi_awready = aw_acc;
    assign s_axi_wready  = aw_acc;
    assign s_axi_arready = ar_acc;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rvalid  = rvalid_q;

    // A command state holds NOP while cnt runs down, then issues and reloads cnt with the
    // spacing to the following command.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        init_cnt_nx = init_cnt;
        init_ref_nx = init_ref;
        cmd_nx      = CMD_NOP;
        addr_nx     = '0;
        ba_nx       = '0;
        dq_oe_nx    = 1'b0;
        dq_out_nx   = '0;
        aw_acc      = 1'b0;
        ar_acc      = 1'b0;
        rd_start    = 1'b0;
        ref_issue   = 1'b0;
        mrs_issue   = 1'b0;
        if (cnt != '0) begin
            cnt_nx = cnt - 1'b1;
        end else begin
            case (state)
                INIT_WAIT: begin
                    if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_nx = INIT_PRE;
                    else init_cnt_nx = init_cnt + 1'b1;
                end
                INIT_PRE: begin
                    cmd_nx      = CMD_PRE;
                    addr_nx[10] = 1'b1;
                    cnt_nx      = CNT_W'(T_RP - 1);
                    state_nx    = INIT_REF;
                end
                INIT_REF: begin
                    cmd_nx      = CMD_REF;
                    cnt_nx      = CNT_W'(T_RFC - 1);
                    init_ref_nx = 1'b1;
                    if (init_ref) state_nx = INIT_MRS;
                end
                INIT_MRS: begin
                    cmd_nx    = CMD_LMR;
                    addr_nx   = MODE_WORD;
                    cnt_nx    = CNT_W'(T_MRD - 1);
                    mrs_issue = 1'b1;
                    state_nx  = IDLE;
                end
                IDLE: begin
                    if (ref_pending) begin
                        cmd_nx    = CMD_REF;
                        cnt_nx    = CNT_W'(T_RFC - 1);
                        ref_issue = 1'b1;
                    end else if (s_axi_awvalid && s_axi_wvalid) begin
                        aw_acc   = 1'b1;
                        cmd_nx   = CMD_ACT;
                        ba_nx    = s_axi_awaddr[11:10];
                        addr_nx  = s_axi_awaddr[24:12];
                        cnt_nx   = CNT_W'(T_RCD - 1);
                        state_nx = WR_CMD;
                    end else if (s_axi_arvalid && !rvalid_q) begin
                        ar_acc   = 1'b1;
                        cmd_nx   = CMD_ACT;
                        ba_nx    = s_axi_araddr[11:10];
                        addr_nx  = s_axi_araddr[24:12];
                        cnt_nx   = CNT_W'(T_RCD - 1);
                        state_nx = RD_CMD;
                    end
                end
                WR_CMD: begin
                    cmd_nx    = CMD_WRITE;
                    ba_nx     = acc_ba;
                    addr_nx   = {2'b00, 1'b1, acc_col};
                    dq_oe_nx  = 1'b1;
                    dq_out_nx = acc_data;
                    cnt_nx    = CNT_W'(T_WR + T_RP - 1);
                    state_nx  = IDLE;
                end
                RD_CMD: begin
                    cmd_nx   = CMD_READ;
                    ba_nx    = acc_ba;
                    addr_nx  = {2'b00, 1'b1, acc_col};
                    rd_start = 1'b1;
                    cnt_nx   = CNT_W'(RD_GAP - 1);
                    state_nx = IDLE;
                end
                default: state_nx = INIT_WAIT;
            endcase
        end
        if (reset) begin
            aw_acc = 1'b0;
            ar_acc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= INIT_WAIT;
            cnt         <= '0;
            init_cnt    <= '0;
            init_ref    <= 1'b0;
            init_done   <= 1'b0;
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
            cmd         <= CMD_DESEL;
            addr_q      <= '0;
            ba_q        <= '0;
            cke_q       <= 1'b0;
            dq_oe       <= 1'b0;
            dq_out      <= '0;
            acc_ba      <= '0;
            acc_col     <= '0;
            acc_data    <= '0;
            rd_pipe     <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            init_cnt <= init_cnt_nx;
            init_ref <= init_ref_nx;
            cmd      <= cmd_nx;
            addr_q   <= addr_nx;
            ba_q     <= ba_nx;
            cke_q    <= 1'b1;
            dq_oe    <= dq_oe_nx;
            dq_out   <= dq_out_nx;
            if (mrs_issue) init_done <= 1'b1;

            if (ref_issue) ref_pending <= 1'b0;
            if (init_done) begin
                if (ref_cnt == REF_W'(REFRESH_INTERVAL - 1)) begin
                    ref_cnt     <= '0;
                    ref_pending <= 1'b1;
                end else begin
                    ref_cnt <= ref_cnt + 1'b1;
                end
            end

            if (aw_acc) begin
                acc_ba   <= s_axi_awaddr[11:10];
                acc_col  <= s_axi_awaddr[9:0];
                acc_data <= s_axi_wdata;
            end else if (ar_acc) begin
                acc_ba  <= s_axi_araddr[11:10];
                acc_col <= s_axi_araddr[9:0];
            end

            // Top pipe bit marks the edge CAS_LATENCY+1 cycles after READ reached the pins.
            rd_pipe <= {rd_pipe[CAS_LATENCY-1:0], rd_start};
            if (rd_pipe[CAS_LATENCY]) begin
                rdata_q  <= sdram_dq;
                rvalid_q <= 1'b1;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sdram_axi_controller.sv
// Directed bench for sdram_axi_controller with a small x16 SDRAM behavioural model.
module tb_sdram_axi_controller;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;
    wire  [15:0] sdram_dq;
    logic        sdram_clk, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic        sdram_dqml, sdram_dqmh;
    logic [24:0] s_axi_araddr = '0, s_axi_awaddr = '0;
    logic        s_axi_arvalid = 1'b0, s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0;
    logic        s_axi_rready = 1'b1;
    logic [15:0] s_axi_wdata = '0;
    logic        s_axi_arready, s_axi_rvalid, s_axi_awready, s_axi_wready;
    logic [15:0] s_axi_rdata;

    logic        mdl_oe = 1'b0;
    logic [15:0] mdl_dq = '0;
    assign sdram_dq = mdl_oe ? mdl_dq : 16'bz;

    logic [3:0] cmd;
    assign cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

    int errors = 0;
    int checks = 0;

    sdram_axi_controller dut (
        .clk(clk), .reset(reset),
        .sdram_addr(sdram_addr), .sdram_ba(sdram_ba), .sdram_dq(sdram_dq),
        .sdram_clk(sdram_clk), .sdram_cke(sdram_cke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_dqml(sdram_dqml), .sdram_dqmh(sdram_dqmh),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SDRAM model and bus monitor, sampled mid-cycle after the tasks drive inputs.
    logic [15:0] mem [logic [24:0]];
    logic [12:0] open_row [4];
    logic        rd_pend = 1'b0;
    int unsigned rd_due, rd_cyc, act_cyc, wr_cyc, rv_rise_cyc;
    logic [24:0] rd_key;
    logic [1:0]  act_ba;
    logic [12:0] act_row, wr_addr;
    logic [15:0] wr_data;
    logic        rv_prev = 1'b0;
    int          rdy_seen = 0;
    int unsigned ref_q[$];

    always begin
        @(negedge clk);
        #1;
        if (mdl_oe) mdl_oe = 1'b0;
        if (reset) rd_pend = 1'b0;
        if (rd_pend && cyc == rd_due) begin
            mdl_dq  = mem.exists(rd_key) ? mem[rd_key] : 16'hDEAD;
            mdl_oe  = 1'b1;
            rd_pend = 1'b0;
        end
        if (s_axi_arready || s_axi_awready || s_axi_wready) rdy_seen++;
        if (s_axi_rvalid && !rv_prev) rv_rise_cyc = cyc;
        rv_prev = s_axi_rvalid;
        case (cmd)
            CMD_ACT: begin
                open_row[sdram_ba] = sdram_addr;
                act_cyc = cyc; act_ba = sdram_ba; act_row = sdram_addr;
            end
            CMD_WRITE: begin
                wr_cyc = cyc; wr_addr = sdram_addr; wr_data = sdram_dq;
                mem[{open_row[sdram_ba], sdram_ba, sdram_addr[9:0]}] = sdram_dq;
            end
            CMD_READ: begin
                rd_pend = 1'b1; rd_due = cyc + 2; rd_cyc = cyc;
                rd_key  = {open_row[sdram_ba], sdram_ba, sdram_addr[9:0]};
            end
            CMD_REF: ref_q.push_back(cyc);
            default: ;
        endcase
    end

    task automatic wait_cmd(output logic [3:0] c, output int gap);
        c = 4'b1111;
        gap = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            gap++;
            if (cmd != CMD_NOP) begin
                c = cmd;
                return;
            end
        end
    endtask

    task automatic do_write(input logic [24:0] a, input logic [15:0] d, output bit ok);
        ok = 1'b0;
        s_axi_awaddr = a; s_axi_wdata = d;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            #1;
            if (s_axi_awready && s_axi_wready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [24:0] a, output logic [15:0] d, output bit ok,
                           output logic rv_after);
        ok = 1'b0; d = '0; rv_after = 1'b1;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            #1;
            if (s_axi_arready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_axi_arvalid = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (s_axi_rvalid) begin
                    ok = 1'b1;
                    d = s_axi_rdata;
                    break;
                end
                @(negedge clk);
            end
            if (ok) begin
                @(negedge clk);
                rv_after = s_axi_rvalid;
            end
        end
    endtask

    task automatic init_sequence(input string tag);
        logic [3:0] c;
        int gap, nops;
        bit rv_seen;
        nops = 0; rv_seen = 1'b0;
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk);
            if (s_axi_rvalid) rv_seen = 1'b1;
            if (cmd != CMD_NOP) break;
            if (sdram_cke) nops++;
        end
        checks++;
        if (nops !== 20000) begin errors++; $display("FAIL %s_nop_count got %0d want 20000", tag, nops); end
        checks++;
        if (cmd !== CMD_PRE || sdram_addr[10] !== 1'b1) begin
            errors++; $display("FAIL %s_precharge_all cmd=%b a10=%b want 0010/1", tag, cmd, sdram_addr[10]);
        end
        wait_cmd(c, gap);
        checks++;
        if (c !== CMD_REF || gap !== 2) begin errors++; $display("FAIL %s_ref1 cmd=%b gap=%0d want 0001/2", tag, c, gap); end
        wait_cmd(c, gap);
        checks++;
        if (c !== CMD_REF || gap !== 7) begin errors++; $display("FAIL %s_ref2 cmd=%b gap=%0d want 0001/7", tag, c, gap); end
        wait_cmd(c, gap);
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        checks++;
        if (c !== CMD_LMR || gap !== 7 || sdram_addr !== 13'h020 || sdram_ba !== 2'd0) begin
            errors++;
            $display("FAIL %s_load_mode cmd=%b gap=%0d addr=%h ba=%0d want 0000/7/020/0", tag, c, gap, sdram_addr, sdram_ba);
        end
        checks++;
        if (rv_seen !== 1'b0) begin errors++; $display("FAIL %s_rvalid_in_init got 1 want 0", tag); end
    endtask

    task automatic test_reset();
        int rdy0;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (sdram_cke !== 1'b0 || cmd !== 4'b1111) begin
            errors++; $display("FAIL reset_cmd cke=%b cmd=%b want 0/1111", sdram_cke, cmd);
        end
        checks++;
        if (sdram_addr !== 13'h0 || sdram_ba !== 2'd0 || sdram_dqml !== 1'b0 || sdram_dqmh !== 1'b0) begin
            errors++; $display("FAIL reset_addr addr=%h ba=%0d dqm=%b%b want 0/0/00", sdram_addr, sdram_ba, sdram_dqmh, sdram_dqml);
        end
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_rdata !== 16'h0 || s_axi_arready !== 1'b0 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin
            errors++; $display("FAIL reset_axi rvalid=%b rdata=%h ar=%b aw=%b w=%b want all 0",
                               s_axi_rvalid, s_axi_rdata, s_axi_arready, s_axi_awready, s_axi_wready);
        end
        reset = 1'b0;
        s_axi_arvalid = 1'b1; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        rdy0 = rdy_seen;
        init_sequence("init");
        checks++;
        if (rdy_seen - rdy0 !== 0) begin errors++; $display("FAIL init_ready_pulses got %0d want 0", rdy_seen - rdy0); end
    endtask

    task automatic test_write_read();
        bit ok; logic [15:0] d; logic rva;
        int unsigned act0;
        do_write(25'd1, 16'h0001, ok);
        repeat (5) @(negedge clk);
        #2;
        checks++;
        if (!ok || act_ba !== 2'd0 || act_row !== 13'h0) begin
            errors++; $display("FAIL wr1_active ok=%0d ba=%0d row=%h want 1/0/0000", ok, act_ba, act_row);
        end
        checks++;
        if (wr_addr !== 13'h401 || wr_data !== 16'h0001 || wr_cyc - act_cyc !== 2) begin
            errors++; $display("FAIL wr1_write addr=%h dq=%h trcd=%0d want 401/0001/2", wr_addr, wr_data, wr_cyc - act_cyc);
        end
        act0 = act_cyc;
        do_read(25'd1, d, ok, rva);
        checks++;
        if (!ok || d !== 16'h0001) begin errors++; $display("FAIL rd1_data ok=%0d rdata=%h want 1/0001", ok, d); end
        checks++;
        if (rv_rise_cyc - rd_cyc !== 3 || act_cyc == act0) begin
            errors++; $display("FAIL rd1_latency got %0d want 3", rv_rise_cyc - rd_cyc);
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2; logic [15:0] d; logic rva;
        s_axi_rready = 1'b1;
        for (int i = 2; i <= 3; i++) begin
            do_write(25'(i), 16'(i), ok1);
            do_read(25'(i), d, ok2, rva);
            checks++;
            if (!ok1 || !ok2 || d !== 16'(i) || rva !== 1'b0) begin
                errors++; $display("FAIL b2b_%0d okw=%0d okr=%0d rdata=%h rvalid_next=%b want 1/1/%h/0", i, ok1, ok2, d, rva, 16'(i));
            end
        end
    endtask

    task automatic test_hold();
        bit ok; logic [15:0] d; logic rva;
        int bad_ar, bad_hold;
        s_axi_rready = 1'b0;
        do_write(25'h0A5, 16'h1234, ok);
        do_read(25'h0A5, d, ok, rva);
        checks++;
        if (!ok || d !== 16'h1234 || rva !== 1'b1) begin
            errors++; $display("FAIL hold_first ok=%0d rdata=%h rvalid=%b want 1/1234/1", ok, d, rva);
        end
        s_axi_araddr = 25'd2; s_axi_arvalid = 1'b1;
        bad_ar = 0; bad_hold = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s_axi_arready) bad_ar++;
            if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 16'h1234) bad_hold++;
            @(negedge clk);
        end
        checks++;
        if (bad_ar !== 0 || bad_hold !== 0) begin
            errors++; $display("FAIL hold_stable arready_cycles=%0d unstable_cycles=%0d want 0/0", bad_ar, bad_hold);
        end
        s_axi_arvalid = 1'b0;
        do_write(25'h055, 16'h5555, ok);
        checks++;
        if (!ok || s_axi_rvalid !== 1'b1 || s_axi_rdata !== 16'h1234) begin
            errors++; $display("FAIL hold_write_ok ok=%0d rvalid=%b rdata=%h want 1/1/1234", ok, s_axi_rvalid, s_axi_rdata);
        end
        s_axi_rready = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL hold_release rvalid=%b want 0", s_axi_rvalid); end
        do_read(25'h055, d, ok, rva);
        checks++;
        if (!ok || d !== 16'h5555) begin errors++; $display("FAIL hold_readback ok=%0d rdata=%h want 1/5555", ok, d); end
    endtask

    task automatic test_refresh();
        bit ok;
        int n0;
        ref_q.delete();
        repeat (2000) @(negedge clk);
        #2;
        checks++;
        if (ref_q.size() < 2) begin
            errors++; $display("FAIL refresh_count got %0d want >=2", ref_q.size());
        end else if (ref_q[1] - ref_q[0] !== 750) begin
            errors++; $display("FAIL refresh_interval got %0d want 750", ref_q[1] - ref_q[0]);
        end
        n0 = ref_q.size();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            #2;
            if (ref_q.size() != n0) break;
        end
        do_write(25'h100, 16'h7777, ok);
        repeat (4) @(negedge clk);
        #2;
        checks++;
        if (!ok || ref_q.size() == n0 || act_cyc - ref_q[$] !== 7) begin
            errors++; $display("FAIL refresh_then_active ok=%0d gap=%0d want 1/7", ok, act_cyc - ref_q[$]);
        end
    endtask

    task automatic test_boundary_reset();
        bit ok; logic [15:0] d; logic rva;
        do_write(25'h1FFFFFF, 16'hBEEF, ok);
        repeat (5) @(negedge clk);
        #2;
        checks++;
        if (!ok || act_ba !== 2'd3 || act_row !== 13'h1FFF || wr_addr !== 13'h7FF) begin
            errors++; $display("FAIL max_addr ok=%0d ba=%0d row=%h waddr=%h want 1/3/1fff/07ff", ok, act_ba, act_row, wr_addr);
        end
        do_read(25'h1FFFFFF, d, ok, rva);
        checks++;
        if (!ok || d !== 16'hBEEF) begin errors++; $display("FAIL max_readback ok=%0d rdata=%h want 1/beef", ok, d); end
        s_axi_rready = 1'b0;
        s_axi_araddr = 25'h1FFFFFF; s_axi_arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            #1;
            if (s_axi_arready) begin ok = 1'b1; @(negedge clk); break; end
            @(negedge clk);
        end
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || s_axi_rvalid !== 1'b0 || sdram_cke !== 1'b0 || cmd !== 4'b1111) begin
            errors++; $display("FAIL midread_reset ok=%0d rvalid=%b cke=%b cmd=%b want 1/0/0/1111", ok, s_axi_rvalid, sdram_cke, cmd);
        end
        reset = 1'b0;
        s_axi_rready = 1'b1;
        init_sequence("reinit");
        do_read(25'h1FFFFFF, d, ok, rva);
        checks++;
        if (!ok || d !== 16'hBEEF) begin errors++; $display("FAIL reinit_read ok=%0d rdata=%h want 1/beef", ok, d); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_hold();
        test_refresh();
        test_boundary_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdram_axi_controller.md
Name:
sdram_axi_controller

Overview:
- Single-word SDRAM controller bridging a simplified AXI-style read/write slave port to one 512 Mb x16 SDR SDRAM device (8M x 16 x 4 banks, -6A speed grade, 100 MHz system clock).
- Performs power-up initialisation and periodic auto-refresh.
- Serves each access as ACTIVE followed by READ or WRITE with auto-precharge (closed-page policy).
- No burst support and no write response channel.

Parameters:
- ADDR_WIDTH, 25, word address width: row = addr[24:12], bank = addr[11:10], column = addr[9:0].
- DATA_WIDTH, 16, data word width.
- INIT_CYCLES, 20000, power-up wait before the first command (200 us).
- REFRESH_INTERVAL, 750, clock cycles between auto-refreshes.
- T_RP, 2, PRECHARGE to next command, in cycles.
- T_RCD, 2, ACTIVE to READ/WRITE, in cycles.
- T_RFC, 7, AUTO REFRESH to next command, in cycles.
- T_MRD, 2, LOAD MODE to next command, in cycles.
- T_WR, 2, write recovery before auto-precharge starts, in cycles.
- CAS_LATENCY, 2, READ to data, in cycles (2 or 3).

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- sdram_addr  out  13  row/column/mode address
- sdram_ba  out  2  bank address
- sdram_dq  inout  16  data bus
- sdram_clk  out  1  SDRAM clock, equal to ~clk
- sdram_cke  out  1  clock enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
- sdram_dqml, sdram_dqmh  out  1 each  byte masks, always 0 after reset
- s_axi_araddr  in  25  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address accepted
- s_axi_rdata  out  16  read data
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data accepted
- s_axi_awaddr  in  25  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address accepted
- s_axi_wdata  in  16  write data
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data accepted

Behaviour:
- Command encoding (cs_n, ras_n, cas_n, we_n):
  - NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, REFRESH 0001, LOAD MODE 0000.
  - Every cycle without a listed command is NOP.
- Reset values (synchronous, clk rising edge): cke=0, cs_n=ras_n=cas_n=we_n=1, addr=0, ba=0, dq released (Z), dqm=0, arready=awready=wready=0, rvalid=0, rdata=0. State=INIT_WAIT with counters cleared.
- Reset asserted mid-operation aborts any access, discards pending rvalid and restarts the full init sequence.
- INIT_WAIT: cke=1, NOP for INIT_CYCLES.
- INIT_PRE: PRECHARGE with addr[10]=1 (all banks), then wait T_RP.
- INIT_REF: two REFRESH commands, each followed by T_RFC.
- INIT_MRS: LOAD MODE with ba=0, addr = {3'b0, 1'b0, 2'b00, CAS_LATENCY[2:0], 1'b0, 3'b000}, i.e. burst length 1, sequential, programmed CL. Then wait T_MRD and go to IDLE.
- Refresh counter:
  - Starts on IDLE entry and counts continuously.
  - On reaching REFRESH_INTERVAL, sets refresh_pending and reloads.
- IDLE priority: refresh_pending > write (awvalid & wvalid) > read (arvalid, and rvalid==0).
- Refresh: REFRESH command, wait T_RFC, clear refresh_pending, return to IDLE.
- Write:
  - In IDLE: awready=wready=1 for exactly one cycle; latch address and data; issue ACTIVE (ba, addr=row).
  - Wait T_RCD, then WRITE with addr = {2'b0, 1'b1 (auto-precharge), col}.
  - dq driven with the data only in the WRITE command cycle.
  - Wait T_WR+T_RP, then IDLE.
  - A write is never accepted with only one of awvalid or wvalid high.
- Read:
  - In IDLE: arready=1 for one cycle; latch address; ACTIVE; wait T_RCD; READ with auto-precharge.
  - Capture sdram_dq into s_axi_rdata on the rising clk edge CAS_LATENCY+1 cycles after the READ edge and set rvalid=1.
  - Wait until tRP from auto-precharge is met, then IDLE.
- rvalid and rdata hold until rvalid & rready; rvalid clears on that edge.
- No new read is accepted while rvalid=1. Writes may still proceed.
- arready, awready and wready are single-cycle pulses, never high outside IDLE, never high during init.
- Addresses span the full 25-bit range: max 0x1FFFFFF → row 0x1FFF, bank 3, column 0x3FF.
- Single outstanding access; a refresh never interrupts an access in progress.

Test Plan:
- Reset 4 cycles, release -> 20000 NOPs with cke=1, then PRECHARGE all (addr[10]=1), 2 REFRESH, LOAD MODE addr=0x020. arready/awready stay low throughout.
- write(addr 1, data 1), then read(1) -> ACTIVE row 0 bank 0, WRITE col 1 with A10=1 and dq=0x0001; read returns rdata=0x0001 with rvalid=1.
- write 2/read 2 and write 3/read 3 back-to-back with rready=1 -> rdata 0x0002 then 0x0003, each rvalid one cycle.
- rready held 0 after a read of a written address, arvalid asserted again -> rvalid and rdata stable, arready stays 0 until rready=1.
- Idle 2000 cycles after init -> REFRESH issued every 750 cycles. A write arriving with refresh pending waits T_RFC before ACTIVE.
- Write 0xBEEF to 0x1FFFFFF, read back -> ACTIVE ba=3 row=0x1FFF, col 0x3FF, rdata=0xBEEF. Assert reset during the read -> rvalid=0 and init restarts.
